// File: rtl/dice_pkg.sv
// Shared types and defaults for the dice roller datapath.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for bringing an asynchronous level into clk.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; only q is safe to use downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/roll_button_conditioner.sv
// Debounces the roll pushbutton, emitting one roll strobe per press plus a
// debounced level and a saturating count of accepted presses.
module roll_button_conditioner
  import dice_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ROLLS_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_raw,
  output logic               roll,
  output logic               pressed,
  output logic [ROLLS_W-1:0] roll_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  btn_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             roll_n;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      roll    <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      roll    <= roll_n;
      // Decoded from next state so pressed rises together with roll.
      pressed <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end
  end

  // Saturating count of accepted presses, one cycle behind roll.
  always_ff @(posedge clk) begin
    if (reset) begin
      roll_count <= '0;
    end else if (roll && (roll_count != '1)) begin
      roll_count <= roll_count + ROLLS_W'(1);
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    roll_n  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          roll_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Scoreboard bench for roll_button_conditioner with a short debounce window.
module tb_roll_button_conditioner;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b0;
  logic       roll;
  logic       pressed;
  logic [7:0] roll_count;

  roll_button_conditioner #(
    .DEBOUNCE_CYCLES (N),
    .ROLLS_W         (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .roll       (roll),
    .pressed    (pressed),
    .roll_count (roll_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       roll;
    bit       pressed;
    int       rc;
  } exp_t;

  exp_t q_exp[$];

  int checks = 0;
  int errors = 0;
  int ecnt = 0;          // index of the most recent rising edge
  int rolls_seen = 0;
  int last_roll_edge = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  // Reference model: sync chain as plain shift, FSM as small integer phase.
  int  m_s1 = 0, m_s2 = 0, m_ph = 0, m_cnt = 0, m_rc = 0;
  bit  m_roll = 0, m_pr = 0;

  always @(posedge clk) begin
    exp_t e;
    int   btn;
    bit   prev_roll;
    ecnt++;
    btn = int'(btn_raw);
    prev_roll = m_roll;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_ph = 0; m_cnt = 0; m_rc = 0; m_roll = 0; m_pr = 0;
    end else begin
      m_roll = 0;
      if (m_ph == 0) begin
        if (m_s2 == 1) begin m_ph = 1; m_cnt = 0; end
      end else if (m_ph == 1) begin
        if (m_s2 == 0) begin m_ph = 0; m_cnt = 0; end
        else if (m_cnt == N - 1) begin m_ph = 2; m_cnt = 0; m_roll = 1; end
        else m_cnt++;
      end else if (m_ph == 2) begin
        if (m_s2 == 0) begin m_ph = 3; m_cnt = 0; end
      end else begin
        if (m_s2 == 1) begin m_ph = 2; m_cnt = 0; end
        else if (m_cnt == N - 1) m_ph = 0;
        else m_cnt++;
      end
      if (prev_roll && m_rc < 255) m_rc++;
      m_pr = (m_ph >= 2);
      m_s2 = m_s1;
      m_s1 = btn;
    end
    e.roll = m_roll; e.pressed = m_pr; e.rc = m_rc;
    q_exp.push_back(e);
  end

  // Pop one expectation per edge and compare, sampled 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_exp.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = q_exp.pop_front();
      chk("roll", int'(roll), int'(e.roll));
      chk("pressed", int'(pressed), int'(e.pressed));
      chk("roll_count", int'(roll_count), e.rc);
    end
    if (roll) begin
      rolls_seen++;
      last_roll_edge = ecnt;
    end
  end

  task automatic drive(input bit b, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      btn_raw = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    int rst_edge;

    // 1. reset values, then a clean long press
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_roll", int'(roll), 0);
    chk("rst_pressed", int'(pressed), 0);
    chk("rst_count", int'(roll_count), 0);
    drive(1'b0, 6);
    rolls_seen = 0;
    @(negedge clk);
    btn_raw = 1'b1;
    t0 = ecnt + 1;
    drive(1'b1, 49);
    chk("s1_latency", last_roll_edge - t0, N + 2);
    chk("s1_rolls", rolls_seen, 1);
    chk("s1_count", int'(roll_count), 1);
    chk("s1_pressed", int'(pressed), 1);
    drive(1'b0, 12);
    chk("s1_released", int'(pressed), 0);

    // 2. bounce on press, then hold
    rolls_seen = 0;
    drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
    @(negedge clk);
    btn_raw = 1'b1;
    t0 = ecnt + 1;
    drive(1'b1, 20);
    chk("s2_rolls", rolls_seen, 1);
    chk("s2_latency", last_roll_edge - t0, N + 2);
    drive(1'b0, 12);

    // 3. glitch shorter than the debounce window
    do_reset();
    drive(1'b0, 4);
    rolls_seen = 0;
    drive(1'b1, 3);
    drive(1'b0, 15);
    chk("s3_rolls", rolls_seen, 0);
    chk("s3_pressed", int'(pressed), 0);
    chk("s3_count", int'(roll_count), 0);

    // 4. release bounce after an accepted press
    drive(1'b1, 12);
    rolls_seen = 0;
    drive(1'b0, 2); drive(1'b1, 1); drive(1'b0, 3);
    chk("s4_hold_pressed", int'(pressed), 1);
    drive(1'b0, 12);
    chk("s4_rolls", rolls_seen, 0);
    chk("s4_pressed", int'(pressed), 0);
    chk("s4_count", int'(roll_count), 1);

    // 5. saturation of roll_count
    do_reset();
    drive(1'b0, 4);
    rolls_seen = 0;
    for (int p = 0; p < 260; p++) begin
      drive(1'b1, N + 4);
      drive(1'b0, N + 4);
    end
    drive(1'b0, 4);
    chk("s5_rolls", rolls_seen, 260);
    chk("s5_count", int'(roll_count), 255);

    // 6. reset while held in PRESSED
    do_reset();
    drive(1'b1, 12);
    chk("s6_pressed_before", int'(pressed), 1);
    rolls_seen = 0;
    @(negedge clk);
    reset = 1'b1;
    rst_edge = ecnt + 1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6_rst_pressed", int'(pressed), 0);
    chk("s6_rst_count", int'(roll_count), 0);
    drive(1'b1, 15);
    chk("s6_rolls", rolls_seen, 1);
    chk("s6_latency", last_roll_edge - rst_edge, N + 3);
    chk("s6_count", int'(roll_count), 1);

    drive(1'b0, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
